// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: three-way round-robin arbiter that hands a shared node
// memory to one requester at a time.
// FSM IDLE -> START -> BUSY -> RELEASE -> IDLE. The owner's address, write
// data and write enable reach the memory through a mux driven by the grant.
// The owner gets a one-cycle start pulse and keeps the memory until it
// pulses done_in.
// Optional feature macro: NODE_MEM_WATCHDOG_EN adds a BUSY-cycle watchdog.
// When it fires, the grant is released and timeout pulses for one cycle.
module node_mem_arbiter #(
  parameter int unsigned WATCHDOG_CYCLES = 1024,
  parameter int unsigned NREQ            = 3
) (
  input  logic            clock,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done_in,
  input  logic [10:0]     addr0,
  input  logic [10:0]     addr1,
  input  logic [10:0]     addr2,
  input  logic [15:0]     wdata0,
  input  logic [15:0]     wdata1,
  input  logic [15:0]     wdata2,
  input  logic            wr_en0,
  input  logic            wr_en1,
  input  logic            wr_en2,
  input  logic [15:0]     mem_rdata,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] start,
  output logic [10:0]     mem_addr,
  output logic [15:0]     mem_wdata,
  output logic            mem_wr_en,
  output logic [15:0]     rdata,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_grant_next;
  logic [1:0]      r_owner;
  logic [1:0]      w_owner_next;
  logic [1:0]      r_last_owner;
  logic [1:0]      w_last_owner_next;
  logic [NREQ-1:0] r_start;
  logic [NREQ-1:0] w_start_next;
  logic            r_done_pend;
  logic            w_done_pend_next;
  logic            r_timeout;
  logic            w_timeout_next;

  logic [1:0]      w_rr_first;
  logic [1:0]      w_rr_second;
  logic [1:0]      w_rr_third;
  logic [1:0]      w_rr_pick;
  logic            w_owner_done;
  logic            w_wd_expire;

  // Wrap-around successor of a requester index (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Request bit selected by an index, written as a case so that index 3
  // can never reach past the 3-bit vector.
  function automatic logic req_bit(input logic [2:0] r, input logic [1:0] idx);
    case (idx)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  // The owner's done pulse is picked out by the grant.
  // done_in bits from non-owners are masked off here.
  assign w_owner_done = |(done_in & r_grant);

`ifdef NODE_MEM_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);

  logic [15:0] r_wd_cnt;

  // Watchdog counter: cleared on the START->BUSY edge, then counts BUSY cycles.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_wd_expire = (r_state == ST_BUSY) && (r_wd_cnt == WD_LAST);
`else
  // Without the watchdog, BUSY ends only on the owner's done pulse.
  assign w_wd_expire = 1'b0;
`endif

  // Round-robin search order: start one past the previous owner and wrap.
  always_comb begin
    w_rr_first  = next_idx(r_last_owner);
    w_rr_second = next_idx(w_rr_first);
    w_rr_third  = next_idx(w_rr_second);
    w_rr_pick   = w_rr_third;
    if (req_bit(req, w_rr_first)) begin
      w_rr_pick = w_rr_first;
    end else if (req_bit(req, w_rr_second)) begin
      w_rr_pick = w_rr_second;
    end
  end

  // State and output registers.
  // Reset sets last_owner to 2 so that requester 0 wins the first arbitration.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_start      <= '0;
      r_done_pend  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_start      <= w_start_next;
      r_done_pend  <= w_done_pend_next;
      r_timeout    <= w_timeout_next;
    end
  end

  // Next-state logic and next register values.
  // The start pulse is registered in the START cycle, so it appears in the
  // first BUSY cycle.
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_start_next      = '0;
    w_done_pend_next  = 1'b0;
    w_timeout_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_owner_next = w_rr_pick;
          w_grant_next = 3'b001 << w_rr_pick;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_start_next = r_grant;
        // The owner may finish before BUSY is reached.
        // Hold its done pulse for one cycle so that it is not lost.
        w_done_pend_next = w_owner_done;
        w_state_next     = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_owner_done || r_done_pend) begin
          w_grant_next = '0;
          w_state_next = ST_RELEASE;
        end else if (w_wd_expire) begin
          w_grant_next   = '0;
          w_timeout_next = 1'b1;
          w_state_next   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_grant_next      = '0;
        w_last_owner_next = r_owner;
        w_state_next      = ST_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Memory-side mux driven by the one-hot grant.
  // Without an owner, every memory-side signal is zero.
  // A non-owner's write enable can therefore never reach the memory.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    case (r_grant)
      3'b001: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wr_en = wr_en0;
      end
      3'b010: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wr_en = wr_en1;
      end
      3'b100: begin
        mem_addr  = addr2;
        mem_wdata = wdata2;
        mem_wr_en = wr_en2;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign start   = r_start;
  assign rdata   = mem_rdata;
  assign busy    = (r_state == ST_START) || (r_state == ST_BUSY);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_node_mem_arbiter.sv
// Directed testbench for node_mem_arbiter.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are checked at the same point, away from the edge.
module tb_node_mem_arbiter;

  logic        clock = 1'b0;
  logic        nrst;
  logic [2:0]  req;
  logic [2:0]  done_in;
  logic [10:0] addr0, addr1, addr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic        wr_en0, wr_en1, wr_en2;
  logic [15:0] mem_rdata;
  logic [2:0]  grant;
  logic [2:0]  start;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr_en;
  logic [15:0] rdata;
  logic        busy;
  logic        timeout;

  int n_pass  = 0;
  int n_total = 0;

  node_mem_arbiter #(.WATCHDOG_CYCLES(16), .NREQ(3)) dut (
    .clock(clock), .nrst(nrst), .req(req), .done_in(done_in),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_en2(wr_en2),
    .mem_rdata(mem_rdata), .grant(grant), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .rdata(rdata), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = 3'b111; done_in = '0;
    addr0 = 11'h011; addr1 = 11'h022; addr2 = 11'h033;
    wdata0 = 16'h1111; wdata1 = 16'h2222; wdata2 = 16'h3333;
    wr_en0 = 1'b1; wr_en1 = 1'b1; wr_en2 = 1'b1; mem_rdata = '0;
    repeat (3) tick();
    n_total++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else n_pass++;
    n_total++; if (start !== 3'b000) $display("FAIL reset_start: got %b want 000", start); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    n_total++; if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); else n_pass++;
    n_total++; if (mem_addr !== 11'h000) $display("FAIL reset_addr: got %h want 000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", mem_wdata); else n_pass++;
    nrst = 1'b1; req = 3'b000;
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single();
    req = 3'b001; addr0 = 11'h274; wdata0 = 16'h1234;
    tick();
    n_total++; if (grant !== 3'b001) $display("FAIL single_grant: got %b want 001", grant); else n_pass++;
    n_total++; if (start !== 3'b000) $display("FAIL single_start_early: got %b want 000", start); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (mem_addr !== 11'h274) $display("FAIL single_addr: got %h want 274", mem_addr); else n_pass++;
    tick();
    n_total++; if (start !== 3'b001) $display("FAIL single_start: got %b want 001", start); else n_pass++;
    addr0 = 11'h155; #1;
    n_total++; if (mem_addr !== 11'h155) $display("FAIL single_addr_follow: got %h want 155", mem_addr); else n_pass++;
    tick();
    n_total++; if (start !== 3'b000) $display("FAIL single_start_pulse: got %b want 000", start); else n_pass++;
    done_in = 3'b001; tick(); done_in = 3'b000; req = 3'b000;
    n_total++; if (grant !== 3'b000) $display("FAIL single_release: got %b want 000", grant); else n_pass++;
    n_total++; if (mem_addr !== 11'h000) $display("FAIL single_addr_idle: got %h want 000", mem_addr); else n_pass++;
    tick();
    $display("single: grant 001 start 001 addr 274");
  endtask

  // All three requesters are held, and each finishes 5 cycles after its
  // start pulse. Between grants, grant is low for RELEASE plus one IDLE
  // evaluation cycle.
  task automatic test_round_robin();
    logic [2:0] order [4];
    int zeros;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    nrst = 1'b0; tick(); nrst = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      zeros = 0;
      while (grant === 3'b000 && zeros < 20) begin zeros++; tick(); end
      n_total++; if (grant !== order[k]) $display("FAIL rr_grant%0d: got %b want %b", k, grant, order[k]); else n_pass++;
      if (k > 0) begin
        n_total++; if (zeros != 2) $display("FAIL rr_gap%0d: got %0d want 2", k, zeros); else n_pass++;
      end
      tick();
      n_total++; if (start !== order[k]) $display("FAIL rr_start%0d: got %b want %b", k, start, order[k]); else n_pass++;
      repeat (4) tick();
      done_in = order[k]; tick(); done_in = 3'b000;
      if (k == 3) req = 3'b000;
      $display("rr: grant %0d = %b", k, order[k]);
    end
    tick(); tick();
  endtask

  task automatic test_nonowner_write();
    req = 3'b010; addr0 = 11'h072; wr_en0 = 1'b1; wdata0 = 16'hFFFF;
    addr1 = 11'h3A5; wdata1 = 16'h5A5A; wr_en1 = 1'b0; mem_rdata = 16'hBEEF;
    tick(); tick();
    n_total++; if (grant !== 3'b010) $display("FAIL nw_grant: got %b want 010", grant); else n_pass++;
    n_total++; if (mem_wr_en !== 1'b0) $display("FAIL nw_wr_blocked: got %b want 0", mem_wr_en); else n_pass++;
    n_total++; if (mem_addr !== 11'h3A5) $display("FAIL nw_addr: got %h want 3a5", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h5A5A) $display("FAIL nw_wdata: got %h want 5a5a", mem_wdata); else n_pass++;
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL nw_rdata: got %h want beef", rdata); else n_pass++;
    wr_en1 = 1'b1; #1;
    n_total++; if (mem_wr_en !== 1'b1) $display("FAIL nw_owner_wr: got %b want 1", mem_wr_en); else n_pass++;
    done_in = 3'b010; tick(); done_in = 3'b000; req = 3'b000;
    n_total++; if (mem_wr_en !== 1'b0) $display("FAIL nw_release_wr: got %b want 0", mem_wr_en); else n_pass++;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    $display("nonowner_write: only wr_en1 reached memory");
  endtask

  task automatic test_done_filter();
    req = 3'b001;
    tick(); tick();
    done_in = 3'b010; tick(); done_in = 3'b000;
    n_total++; if (grant !== 3'b001) $display("FAIL df_ignore: got %b want 001", grant); else n_pass++;
    done_in = 3'b001; tick(); done_in = 3'b000; req = 3'b000;
    n_total++; if (grant !== 3'b000) $display("FAIL df_release: got %b want 000", grant); else n_pass++;
    tick();
    $display("done_filter: foreign done ignored");
  endtask

  task automatic test_done_in_start();
    req = 3'b100;
    tick();
    done_in = 3'b100; tick(); done_in = 3'b000;
    n_total++; if (grant !== 3'b100) $display("FAIL ds_grant: got %b want 100", grant); else n_pass++;
    n_total++; if (start !== 3'b100) $display("FAIL ds_start: got %b want 100", start); else n_pass++;
    tick();
    n_total++; if (grant !== 3'b000) $display("FAIL ds_latched: got %b want 000", grant); else n_pass++;
    req = 3'b000; tick();
    $display("done_in_start: latched done accepted");
  endtask

  task automatic test_owner_drop_req();
    req = 3'b001;
    tick(); tick();
    req = 3'b000;
    repeat (3) tick();
    n_total++; if (grant !== 3'b001) $display("FAIL drop_hold: got %b want 001", grant); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b want 1", busy); else n_pass++;
    done_in = 3'b001; tick(); done_in = 3'b000;
    n_total++; if (grant !== 3'b000) $display("FAIL drop_release: got %b want 000", grant); else n_pass++;
    tick();
    $display("owner_drop_req: grant held until done");
  endtask

  task automatic test_reset_mid_busy();
    req = 3'b100; wr_en2 = 1'b1; addr2 = 11'h6AA;
    tick(); tick();
    n_total++; if (mem_wr_en !== 1'b1) $display("FAIL rb_wr_before: got %b want 1", mem_wr_en); else n_pass++;
    n_total++; if (mem_addr !== 11'h6AA) $display("FAIL rb_addr_before: got %h want 6aa", mem_addr); else n_pass++;
    nrst = 1'b0; tick();
    n_total++; if (grant !== 3'b000) $display("FAIL rb_grant: got %b want 000", grant); else n_pass++;
    n_total++; if (mem_wr_en !== 1'b0) $display("FAIL rb_wr: got %b want 0", mem_wr_en); else n_pass++;
    n_total++; if (start !== 3'b000) $display("FAIL rb_start: got %b want 000", start); else n_pass++;
    nrst = 1'b1; req = 3'b011;
    tick();
    n_total++; if (grant !== 3'b001) $display("FAIL rb_first_after: got %b want 001", grant); else n_pass++;
    tick();
    done_in = 3'b001; tick(); done_in = 3'b000; req = 3'b000;
    tick();
    wr_en2 = 1'b0;
    $display("reset_mid_busy: grant dropped, requester 0 first after reset");
  endtask

`ifdef NODE_MEM_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    req = 3'b110;
    tick(); tick();
    n = 0;
    while (grant !== 3'b000 && n < 100) begin tick(); n++; end
    n_total++; if (n != 16) $display("FAIL wd_cycles: got %0d want 16", n); else n_pass++;
    n_total++; if (timeout !== 1'b1) $display("FAIL wd_timeout: got %b want 1", timeout); else n_pass++;
    tick();
    n_total++; if (timeout !== 1'b0) $display("FAIL wd_timeout_pulse: got %b want 0", timeout); else n_pass++;
    tick();
    n_total++; if (grant !== 3'b100) $display("FAIL wd_next: got %b want 100", grant); else n_pass++;
    req = 3'b000; tick();
    done_in = 3'b100; tick(); done_in = 3'b000; tick();
    $display("watchdog: forced release after %0d busy cycles", n);
  endtask
`else
  task automatic test_watchdog();
    req = 3'b010;
    tick(); tick();
    repeat (40) tick();
    n_total++; if (grant !== 3'b010) $display("FAIL nowd_hold: got %b want 010", grant); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL nowd_timeout: got %b want 0", timeout); else n_pass++;
    done_in = 3'b010; tick(); done_in = 3'b000; req = 3'b000;
    n_total++; if (grant !== 3'b000) $display("FAIL nowd_release: got %b want 000", grant); else n_pass++;
    tick();
    $display("no_watchdog: grant held 40 busy cycles");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nonowner_write();
    test_done_filter();
    test_done_in_start();
    test_owner_drop_req();
    test_reset_mid_busy();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/node_mem_arbiter.md
NODE_MEM_ARBITER -- requirements
Module: node_mem_arbiter

Interface
REQ-001 SHALL provide parameter: WATCHDOG_CYCLES, default 1024, max cycles a grant is held before forced release (used only with NODE_MEM_WATCHDOG_EN).
REQ-002 SHALL provide parameter: NREQ, default 3, number of requesters (fixed at 3 in this revision).
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 req  input  3  per-requester access request, level, held until done.
REQ-006 done_in  input  3  per-requester operation-complete pulse (existing done outputs).
REQ-007 addr0/addr1/addr2  input  11 each  requester memory address.
REQ-008 wdata0/wdata1/wdata2  input  16 each  requester write data.
REQ-009 wr_en0/wr_en1/wr_en2  input  1 each  requester write enable.
REQ-010 mem_rdata  input  16  node memory read data.
REQ-011 grant  output  3  one-hot current owner; 0 when unowned.
REQ-012 start  output  3  one-cycle pulse to owner's en input.
REQ-013 mem_addr  output  11  muxed address to node memory.
REQ-014 mem_wdata  output  16  muxed write data.
REQ-015 mem_wr_en  output  1  muxed write enable.
REQ-016 rdata  output  16  mem_rdata broadcast to all requesters, combinational.
REQ-017 busy  output  1  high in START or BUSY.
REQ-018 timeout  output  1  one-cycle pulse on watchdog release.

Function
REQ-019 SHALL implement states IDLE, START, BUSY, RELEASE.
REQ-020 IDLE: if any req bit set, SHALL pick winner round-robin starting at index (last_owner+1) mod 3, register grant, go START; else stay IDLE.
REQ-021 START: SHALL assert start[owner] for exactly one cycle, hold grant, go BUSY.
REQ-022 BUSY: SHALL pass owner's addr/wdata/wr_en to mem_* each cycle combinationally from grant.
REQ-023 BUSY: done_in[owner]=1 SHALL go RELEASE; done_in of non-owners SHALL be ignored.
REQ-024 BUSY: owner dropping req without done SHALL NOT release grant.
REQ-025 RELEASE: grant=0, mem_wr_en=0, last_owner updated to owner, go IDLE; min gap between grants = 1 idle-evaluation cycle.
REQ-026 When grant=0: mem_addr=0, mem_wdata=0, mem_wr_en=0.
REQ-027 Non-owner wr_en SHALL never reach mem_wr_en in any state.
REQ-028 done_in[owner] asserted in START cycle SHALL be accepted next cycle (BUSY treats it as pending via 1-cycle latch).
REQ-029 Simultaneous req: fairness per REQ-020; a requester waits at most 2 full grants.
REQ-030 grant SHALL be one-hot or zero at all times.

Reset
REQ-031 nrst=0 at clock edge: state=IDLE, grant=0, start=0, timeout=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, last_owner=2 (so requester 0 wins first), watchdog counter=0.
REQ-032 Reset mid-BUSY SHALL drop grant and mem_wr_en the same edge; no start pulse issued.

Configuration
REQ-033 Macro NODE_MEM_WATCHDOG_EN: defined -> 16-bit counter clears on entering BUSY, increments each BUSY cycle; at count WATCHDOG_CYCLES-1 without done, go RELEASE and pulse timeout one cycle.
REQ-034 Undefined -> no counter, timeout tied 0, BUSY exits only on done_in[owner].

Verification
REQ-035 Reset then req=3'b001 -> grant=001 at cycle+1, start[0] pulse at cycle+2, mem_addr follows addr0=0x274.
REQ-036 req=3'b111 all held, each done 5 cycles after start -> grant order 0,1,2,0; idle gap 1 cycle between.
REQ-037 Owner 1, wr_en0=1 addr0=0x72 -> mem_wr_en follows wr_en1 only; no write at 0x72.
REQ-038 Owner 0, done_in=3'b010 -> ignored, grant stays 001; done_in=3'b001 -> grant=000 next cycle.
REQ-039 Watchdog on, WATCHDOG_CYCLES=16, owner never done -> timeout pulse, grant=0 after 16 BUSY cycles; next requester granted.
REQ-040 nrst low during BUSY with wr_en2=1 -> mem_wr_en=0, grant=0 next edge; after release, req=001 granted first.
